// File: rtl/octave_ctrl_if.sv
// Octave controller bus: raw buttons and load strobe toward the block, registered octave status back.
interface octave_ctrl_if #(
  parameter int unsigned OCT_W = 3
);
  logic             up_btn;
  logic             down_btn;
  logic             load;
  logic [OCT_W-1:0] load_val;
  logic [OCT_W-1:0] octave;
  logic             oct_changed;
  logic             at_min;
  logic             at_max;

  modport master (
    output up_btn, down_btn, load, load_val,
    input  octave, oct_changed, at_min, at_max
  );

  modport slave (
    input  up_btn, down_btn, load, load_val,
    output octave, oct_changed, at_min, at_max
  );
endinterface

// File: rtl/octave_ctrl.sv
// Octave register for the piano front end: debounced up/down buttons with auto-repeat,
// direct clamped load, saturating or wrapping bounds.
module octave_ctrl #(
  parameter int unsigned OCT_W       = 3,
  parameter int unsigned OCT_MIN     = 0,
  parameter int unsigned OCT_MAX     = 7,
  parameter int unsigned OCT_RST     = 4,
  parameter int unsigned WRAP        = 0,
  parameter int unsigned DEBOUNCE    = 16,
  parameter int unsigned REPEAT_DLY  = 64,
  parameter int unsigned REPEAT_RATE = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  octave_ctrl_if.slave bus
);

  localparam int unsigned NB     = 2;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
  localparam int unsigned RP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

  localparam logic [OCT_W-1:0] MIN_V     = OCT_W'(OCT_MIN);
  localparam logic [OCT_W-1:0] MAX_V     = OCT_W'(OCT_MAX);
  localparam logic [OCT_W-1:0] RST_V     = OCT_W'(OCT_RST);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [RP_W-1:0]  DLY_LAST  = RP_W'(REPEAT_DLY - 1);
  localparam logic [RP_W-1:0]  RATE_LAST = RP_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_st_e;

  // Index 0 is the up button, index 1 the down button.
  logic [NB-1:0] raw_c;
  logic [NB-1:0] level_c;
  logic [NB-1:0] step_c;
  logic          both_c;

  assign raw_c  = {bus.down_btn, bus.up_btn};
  assign both_c = &level_c;

  for (genvar b = 0; b < NB; b++) begin : g_btn
    logic            sync1_q;
    logic            sync2_q;
    logic            deb_q;
    logic            deb_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    rpt_st_e         st_q;
    rpt_st_e         st_d;
    logic [RP_W-1:0] rp_cnt_q;
    logic [RP_W-1:0] rp_cnt_d;
    logic            step;
    logic            armed;

    // Debounce: flip the level after DEBOUNCE consecutive disagreeing samples.
    always_comb begin
      deb_d    = deb_q;
      db_cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (db_cnt_q == DB_LAST) begin
          deb_d = ~deb_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        deb_q    <= 1'b0;
        db_cnt_q <= '0;
      end else begin
        sync1_q  <= raw_c[b];
        sync2_q  <= sync1_q;
        deb_q    <= deb_d;
        db_cnt_q <= db_cnt_d;
      end
    end

    // A press only counts while this level is high and the other one is not.
    assign armed      = deb_q & ~both_c;
    assign level_c[b] = deb_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q     <= ST_IDLE;
        rp_cnt_q <= '0;
      end else begin
        st_q     <= st_d;
        rp_cnt_q <= rp_cnt_d;
      end
    end

    always_comb begin
      st_d     = st_q;
      rp_cnt_d = rp_cnt_q + RP_W'(1);
      if (!armed) begin
        st_d     = ST_IDLE;
        rp_cnt_d = '0;
      end else begin
        case (st_q)
          ST_IDLE: begin
            st_d     = ST_DELAY;
            rp_cnt_d = '0;
          end
          ST_DELAY: begin
            if (rp_cnt_q == DLY_LAST) begin
              st_d     = ST_REPEAT;
              rp_cnt_d = '0;
            end
          end
          ST_REPEAT: begin
            if (rp_cnt_q == RATE_LAST) begin
              rp_cnt_d = '0;
            end
          end
          default: begin
            st_d     = ST_IDLE;
            rp_cnt_d = '0;
          end
        endcase
      end
    end

    always_comb begin
      step = 1'b0;
      if (armed) begin
        case (st_q)
          ST_IDLE:   step = 1'b1;
          ST_DELAY:  step = (rp_cnt_q == DLY_LAST);
          ST_REPEAT: step = (rp_cnt_q == RATE_LAST);
          default:   step = 1'b0;
        endcase
      end
    end

    assign step_c[b] = step;
  end

  logic [OCT_W-1:0] oct_q;
  logic [OCT_W-1:0] oct_d;
  logic             chg_q;
  logic             chg_d;
  logic             at_min_q;
  logic             at_min_d;
  logic             at_max_q;
  logic             at_max_d;
  logic [OCT_W-1:0] load_clamp_c;

  assign load_clamp_c = (bus.load_val <= MIN_V) ? MIN_V :
                        (bus.load_val >= MAX_V) ? MAX_V : bus.load_val;

  // Load beats steps; simultaneous up and down steps cancel.
  always_comb begin
    oct_d = oct_q;
    if (bus.load) begin
      oct_d = load_clamp_c;
    end else if (step_c[0] ^ step_c[1]) begin
      if (step_c[0]) begin
        if (oct_q == MAX_V) oct_d = (WRAP != 0) ? MIN_V : MAX_V;
        else                oct_d = oct_q + OCT_W'(1);
      end else begin
        if (oct_q == MIN_V) oct_d = (WRAP != 0) ? MAX_V : MIN_V;
        else                oct_d = oct_q - OCT_W'(1);
      end
    end
    chg_d    = (oct_d != oct_q);
    at_min_d = (oct_d == MIN_V);
    at_max_d = (oct_d == MAX_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oct_q    <= RST_V;
      chg_q    <= 1'b0;
      at_min_q <= (RST_V == MIN_V);
      at_max_q <= (RST_V == MAX_V);
    end else begin
      oct_q    <= oct_d;
      chg_q    <= chg_d;
      at_min_q <= at_min_d;
      at_max_q <= at_max_d;
    end
  end

  assign bus.octave      = oct_q;
  assign bus.oct_changed = chg_q;
  assign bus.at_min      = at_min_q;
  assign bus.at_max      = at_max_q;

endmodule

// File: tb/tb_octave_ctrl.sv
// Bench for octave_ctrl: three configurations share one stimulus stream and are checked
// against a press-duration reference model plus a change-event scoreboard.
module tb_octave_ctrl;
  localparam int unsigned W  = 3;
  localparam int          DB = 4;
  localparam int          RD = 8;
  localparam int          RR = 4;
  localparam int          NI = 3;
  localparam int P_MIN  [NI] = '{0, 0, 2};
  localparam int P_MAX  [NI] = '{7, 7, 6};
  localparam int P_RST  [NI] = '{4, 4, 3};
  localparam int P_WRAP [NI] = '{0, 1, 0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         up_r, dn_r, ld_r;
  logic [W-1:0] lv_r;
  bit           mon_en = 1'b0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  octave_ctrl_if #(.OCT_W(W)) if0 ();
  octave_ctrl_if #(.OCT_W(W)) if1 ();
  octave_ctrl_if #(.OCT_W(W)) if2 ();

  assign if0.up_btn = up_r; assign if0.down_btn = dn_r; assign if0.load = ld_r; assign if0.load_val = lv_r;
  assign if1.up_btn = up_r; assign if1.down_btn = dn_r; assign if1.load = ld_r; assign if1.load_val = lv_r;
  assign if2.up_btn = up_r; assign if2.down_btn = dn_r; assign if2.load = ld_r; assign if2.load_val = lv_r;

  octave_ctrl #(.OCT_W(3), .OCT_MIN(0), .OCT_MAX(7), .OCT_RST(4), .WRAP(0),
                .DEBOUNCE(4), .REPEAT_DLY(8), .REPEAT_RATE(4))
    u_sat (.clk(clk), .rst_n(rst_n), .bus(if0));
  octave_ctrl #(.OCT_W(3), .OCT_MIN(0), .OCT_MAX(7), .OCT_RST(4), .WRAP(1),
                .DEBOUNCE(4), .REPEAT_DLY(8), .REPEAT_RATE(4))
    u_wrap (.clk(clk), .rst_n(rst_n), .bus(if1));
  octave_ctrl #(.OCT_W(3), .OCT_MIN(2), .OCT_MAX(6), .OCT_RST(3), .WRAP(0),
                .DEBOUNCE(4), .REPEAT_DLY(8), .REPEAT_RATE(4))
    u_narrow (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [W-1:0] d_oct [NI];
  logic         d_chg [NI];
  logic         d_min [NI];
  logic         d_max [NI];
  assign d_oct[0] = if0.octave; assign d_chg[0] = if0.oct_changed; assign d_min[0] = if0.at_min; assign d_max[0] = if0.at_max;
  assign d_oct[1] = if1.octave; assign d_chg[1] = if1.oct_changed; assign d_min[1] = if1.at_min; assign d_max[1] = if1.at_max;
  assign d_oct[2] = if2.octave; assign d_chg[2] = if2.oct_changed; assign d_min[2] = if2.at_min; assign d_max[2] = if2.at_max;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: raw -> 2-cycle delay -> run-length debounce -> press duration t.
  // A step fires at t==0, t==RD, RD+RR, RD+2RR, ... while exactly one button is down.
  int m_oct [NI];
  bit m_chg [NI];
  bit s1 [2], s2 [2], deb [2];
  int run [2], tt [2];
  int exp_q [$];

  function automatic bit is_step(input int t);
    return (t == 0) || (t >= RD && ((t - RD) % RR) == 0);
  endfunction

  always @(posedge clk) begin
    bit act [2];
    bit st [2];
    int nxt;
    int v;
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        s1[b] = 0; s2[b] = 0; deb[b] = 0; run[b] = 0; tt[b] = 0;
      end
      for (int i = 0; i < NI; i++) begin
        m_oct[i] = P_RST[i]; m_chg[i] = 0;
      end
    end else begin
      act[0] = deb[0] && !deb[1];
      act[1] = deb[1] && !deb[0];
      for (int b = 0; b < 2; b++) st[b] = act[b] && is_step(tt[b]);
      for (int i = 0; i < NI; i++) begin
        nxt = m_oct[i];
        if (ld_r) begin
          v = int'(lv_r);
          nxt = (v < P_MIN[i]) ? P_MIN[i] : (v > P_MAX[i]) ? P_MAX[i] : v;
        end else if (st[0]) begin
          nxt = (m_oct[i] < P_MAX[i]) ? m_oct[i] + 1 : (P_WRAP[i] != 0 ? P_MIN[i] : P_MAX[i]);
        end else if (st[1]) begin
          nxt = (m_oct[i] > P_MIN[i]) ? m_oct[i] - 1 : (P_WRAP[i] != 0 ? P_MAX[i] : P_MIN[i]);
        end
        m_chg[i] = (nxt != m_oct[i]);
        if (m_chg[i]) exp_q.push_back(i * 16 + nxt);
        m_oct[i] = nxt;
      end
      for (int b = 0; b < 2; b++) begin
        tt[b] = act[b] ? tt[b] + 1 : 0;
        if (s2[b] != deb[b]) begin
          run[b]++;
          if (run[b] == DB) begin deb[b] = !deb[b]; run[b] = 0; end
        end else begin
          run[b] = 0;
        end
        s2[b] = s1[b];
      end
      s1[0] = up_r;
      s1[1] = dn_r;
    end
  end

  // Monitor: per-cycle status against the model, change pulses against the scoreboard.
  always @(negedge clk) begin
    int e;
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("oct[%0d]", i), int'(d_oct[i]), m_oct[i]);
        chk($sformatf("chg[%0d]", i), int'(d_chg[i]), int'(m_chg[i]));
        chk($sformatf("at_min[%0d]", i), int'(d_min[i]), int'(m_oct[i] == P_MIN[i]));
        chk($sformatf("at_max[%0d]", i), int'(d_max[i]), int'(m_oct[i] == P_MAX[i]));
        if (d_chg[i]) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("sb_empty[%0d]", i), 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("sb_inst[%0d]", i), e / 16, i);
            chk($sformatf("sb_val[%0d]", i), int'(d_oct[i]), e % 16);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; up_r = 1'b0; dn_r = 1'b0; ld_r = 1'b0; lv_r = '0;
    cyc(2);
    rst_n = 1'b1;
    mon_en = 1'b1;
    chk("rst_oct", int'(d_oct[0]), 4);
    chk("rst_chg", int'(d_chg[0]), 0);
    chk("rst_min", int'(d_min[0]), 0);
    chk("rst_max", int'(d_max[0]), 0);

    // Single press: step lands on the 7th edge, no repeat on a short hold.
    up_r = 1'b1;
    cyc(6); chk("t1_before", int'(d_oct[0]), 4);
    cyc(1); chk("t1_step", int'(d_oct[0]), 5); chk("t1_pulse", int'(d_chg[0]), 1);
    cyc(1); chk("t1_pulse_end", int'(d_chg[0]), 0);
    up_r = 1'b0;
    cyc(14); chk("t1_norep", int'(d_oct[0]), 5);

    // Glitch shorter than the debounce window.
    do_reset();
    chk("t2_rst", int'(d_oct[0]), 4);
    up_r = 1'b1; cyc(3); up_r = 1'b0;
    cyc(14); chk("t2_glitch", int'(d_oct[0]), 4);

    // Held down: first step, delay, repeat, then saturate at 0.
    do_reset();
    dn_r = 1'b1;
    cyc(6); chk("t3_before", int'(d_oct[0]), 4);
    cyc(1); chk("t3_first", int'(d_oct[0]), 3);
    cyc(7); chk("t3_delay", int'(d_oct[0]), 3);
    cyc(1); chk("t3_rep1", int'(d_oct[0]), 2);
    cyc(4); chk("t3_rep2", int'(d_oct[0]), 1);
    cyc(4); chk("t3_rep3", int'(d_oct[0]), 0); chk("t3_atmin", int'(d_min[0]), 1);
    cyc(20); chk("t3_hold", int'(d_oct[0]), 0); chk("t3_nopulse", int'(d_chg[0]), 0);
    dn_r = 1'b0;
    cyc(14);

    // Load 7 then one up press: saturating stays, wrapping goes to 0.
    do_reset();
    ld_r = 1'b1; lv_r = 3'd7;
    cyc(1); ld_r = 1'b0;
    chk("t4_load_sat", int'(d_oct[0]), 7);
    chk("t4_load_wrap", int'(d_oct[1]), 7);
    chk("t4_clamp", int'(d_oct[2]), 6);
    up_r = 1'b1;
    cyc(7);
    chk("t4_wrap_oct", int'(d_oct[1]), 0);
    chk("t4_wrap_chg", int'(d_chg[1]), 1);
    chk("t4_wrap_min", int'(d_min[1]), 1);
    chk("t4_sat_oct", int'(d_oct[0]), 7);
    chk("t4_sat_chg", int'(d_chg[0]), 0);
    cyc(1); up_r = 1'b0;
    cyc(14);

    // Both held: nothing; releasing down re-arms up as a fresh press.
    do_reset();
    up_r = 1'b1; dn_r = 1'b1;
    cyc(20); chk("t5_both", int'(d_oct[0]), 4);
    dn_r = 1'b0;
    cyc(6); chk("t5_before", int'(d_oct[0]), 4);
    cyc(1); chk("t5_rearm", int'(d_oct[0]), 5);
    up_r = 1'b0;
    cyc(14); chk("t5_after", int'(d_oct[0]), 5);

    // Load during auto-repeat, repeat continues, reset mid-hold needs full debounce.
    do_reset();
    up_r = 1'b1;
    cyc(7); chk("t6_first", int'(d_oct[0]), 5);
    cyc(2);
    ld_r = 1'b1; lv_r = 3'd6;
    cyc(1); ld_r = 1'b0;
    chk("t6_load", int'(d_oct[0]), 6); chk("t6_load_chg", int'(d_chg[0]), 1);
    cyc(5); chk("t6_rep", int'(d_oct[0]), 7);
    cyc(4); chk("t6_sat", int'(d_oct[0]), 7); chk("t6_atmax", int'(d_max[0]), 1);
    rst_n = 1'b0;
    cyc(1); chk("t6_rst", int'(d_oct[0]), 4);
    rst_n = 1'b1;
    cyc(6); chk("t6_rst_hold", int'(d_oct[0]), 4);
    cyc(1); chk("t6_repress", int'(d_oct[0]), 5);
    up_r = 1'b0;
    cyc(14);

    // Randomized segments: button levels, loads and rare resets.
    for (int k = 0; k < 250; k++) begin
      int n;
      up_r = 1'($urandom_range(0, 1));
      dn_r = ($urandom_range(0, 3) == 0);
      n = $urandom_range(1, 30);
      for (int c = 0; c < n; c++) begin
        ld_r  = ($urandom_range(0, 19) == 0);
        lv_r  = W'($urandom_range(0, 7));
        rst_n = ($urandom_range(0, 299) != 0);
        cyc(1);
      end
    end
    ld_r = 1'b0; rst_n = 1'b1; up_r = 1'b0; dn_r = 1'b0;
    cyc(20);
    chk("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
